// File: rtl/pwm_tick_generator.sv
// PWM stage: counts rising edges of a divided clock level, produces a
// PERIOD-tick waveform; duty arrives over valid/ready, applied at boundaries.
// Ports: clk, reset (sync, active high), tick_in, enable, duty_in/duty_valid/
// duty_ready, pwm_out, period_start, duty_active, busy.
module pwm_tick_generator #(
  parameter int WIDTH      = 8,
  parameter int PERIOD     = 200,
  parameter int DUTY_RESET = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_active,
  output logic             busy
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] DRST = WIDTH'(DUTY_RESET);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             tick_q_q;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pfull_q, pfull_d;
  logic             pwm_q, pwm_d;
  logic             ps_q, ps_d;

  logic tick_rise;
  logic counting;
  logic boundary;
  logic entry;
  logic load;
  logic xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q_q  <= 1'b0;
      counter_q <= '0;
      duty_q    <= DRST;
      pend_q    <= '0;
      pfull_q   <= 1'b0;
      pwm_q     <= 1'b0;
      ps_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q_q  <= tick_in;
      counter_q <= counter_d;
      duty_q    <= duty_d;
      pend_q    <= pend_d;
      pfull_q   <= pfull_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
    end
  end

  // A level held high produces a single rise.
  assign tick_rise = tick_in & ~tick_q_q;
  assign counting  = (state_q != IDLE);
  assign boundary  = counting & tick_rise
                   & (counter_q == LAST);
  assign entry     = (state_q == IDLE) & enable;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)        state_d = RUN;
        else if (boundary) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    counter_d = counter_q;
    if (entry)
      counter_d = '0;
    else if (counting && tick_rise)
      counter_d = boundary ? '0 : counter_q + WIDTH'(1);

    // Loads use the slot state from before this edge, so a
    // transfer landing on a boundary waits for the next one.
    load    = (boundary | entry) & pfull_q;
    xfer    = duty_valid & ~pfull_q;
    duty_d  = load ? pend_q : duty_q;
    pend_d  = xfer ? duty_in : pend_q;
    pfull_d = xfer | (pfull_q & ~load);

    ps_d  = entry | (boundary & (state_q == RUN));
    // Next-state values keep pwm aligned with the counted tick.
    pwm_d = (state_d != IDLE) & (counter_d < duty_d);
  end

  assign duty_ready   = ~pfull_q;
  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign duty_active  = duty_q;
  assign busy         = (state_q != IDLE);

endmodule
